counter_updown_modload: RTL and testbench
=========================================

// Module: counter_updown_modload
// PURPOSE
//   Parametrised up/down counter: parallel load, programmable upper bound lim_i,
//   programmable step, three overflow modes (wrap / saturate / one-shot).
//   Successor to the fixed-width load counter; used as a timebase, event counter
//   and programmable divider in datapath and control blocks.
// PARAMETERS
//   DATA_WIDTH  8  width of data_i, lim_i and data_o
//   STEP_WIDTH  4  width of step_i
// PORTS
//   Clk     in   1           rising-edge clock
//   RST_N   in   1           asynchronous, active-low reset
//   e_i     in   1           count enable
//   d_i     in   1           direction: 0 = up, 1 = down
//   load_i  in   1           parallel load strobe
//   data_i  in   DATA_WIDTH  load value
//   lim_i   in   DATA_WIDTH  inclusive upper bound; legal range is 0..lim_i
//   step_i  in   STEP_WIDTH  count increment; 0 = hold
//   mode_i  in   2           00 wrap, 01 saturate, 10 one-shot, 11 = wrap
//   data_o  out  DATA_WIDTH  counter value (registered)
//   cout    out  1           one-cycle terminal-event pulse (registered)
//   done_o  out  1           one-shot stopped flag (registered)
// BEHAVIOUR
// - Reset (RST_N=0, async): data_o=0, cout=0, done_o=0, FSM=RUN.
// - All other updates occur on the rising edge of Clk.
// - FSM states: RUN, STOP. STOP is entered only on a one-shot terminal event.
//   STOP is left only by load_i or reset.
// - Priority per edge: load_i > count (e_i=1, state RUN) > hold.
// - Load:
//   - Acts regardless of e_i and state.
//   - data_o <= (data_i > lim_i) ? lim_i : data_i.
//   - cout <= 0, done_o <= 0, FSM <= RUN.
// - Count arithmetic uses DATA_WIDTH+1 bits.
//   - Up:   nxt = data_o + step_i; overflow if nxt > lim_i.
//   - Down: nxt = data_o - step_i; underflow if step_i > data_o.
//   - No over/underflow: data_o <= nxt, cout <= 0.
//   - Reaching exactly lim_i or 0 is not a terminal event.
// - Terminal event (over/underflow). cout <= 1 for exactly that edge, then:
//   - Wrap:      up -> data_o <= 0; down -> data_o <= lim_i.
//   - Saturate:  up -> data_o <= lim_i; down -> data_o <= 0. Stays RUN.
//                Every further enabled count past the bound pulses cout again.
//   - One-shot:  clamp as in saturate; done_o <= 1; FSM <= STOP.
//                In STOP, e_i is ignored; data_o, done_o hold; cout <= 0.
// - step_i=0 with e_i=1: data_o holds, cout <= 0, no terminal event.
// - e_i=0 (no load): data_o holds, cout <= 0.
// - lim_i lowered below data_o at run time:
//   - Next up-count is an overflow (handled per mode).
//   - Down-counts proceed normally until data_o <= lim_i.
// - lim_i=0: every nonzero-step count is a terminal event; data_o stays 0.
// - mode_i changes take effect on the next edge. Leaving one-shot mode does not
//   clear STOP; only load_i or reset does.
// - Latency: one cycle from input to data_o/cout/done_o; no combinational paths
//   from inputs to outputs.
// TESTING
// 1. Reset, e_i=1, d_i=0, step=1, lim=255, wrap: 256 edges -> data_o 0..255,0;
//    cout=1 only on the 255->0 edge. Repeat with d_i=1: 0->255 edge pulses cout.
// 2. lim=9, step=3, wrap, up from 0 -> 3,6,9,0 with cout on the 9->0 edge;
//    down from 9 -> 6,3,0,9 with cout on the 0->9 edge.
// 3. Saturate, lim=200, load 198, step=1, up -> 199,200,200,200;
//    cout=1 on each edge after data_o reaches 200.
// 4. One-shot, lim=5, load 0, step=2 up -> 2,4,5 with cout and done_o=1;
//    further e_i edges hold 5. Then load_i with data=1 -> data_o=1, done_o=0,
//    counting resumes.
// 5. Load/limit corners: load 50 with lim=20 -> data_o=20; load_i and e_i together
//    -> load wins; lim 100->10 while data_o=40, up -> terminal event per mode;
//    step_i=0 -> hold with no cout.
// 6. Assert RST_N mid-count and mid-STOP -> data_o, cout, done_o clear
//    immediately (before the next edge); counting resumes from 0 after release.

Source files
------------

// File: rtl/counter_updown_modload.sv
// Up/down counter with parallel load, programmable inclusive upper bound and step,
// and wrap / saturate / one-shot handling of the terminal (over/underflow) event.
module counter_updown_modload #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  RST_N,
  input  logic                  e_i,
  input  logic                  d_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] lim_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  cout,
  output logic                  done_o
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  cout_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic                  cout_nxt_s;
  logic                  done_nxt_s;

  logic [DATA_WIDTH:0]   step_ext_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic                  ovf_s;
  logic                  unf_s;
  logic                  count_s;
  logic                  term_s;
  logic                  clamp_s;
  logic [DATA_WIDTH-1:0] load_val_s;

  // Arithmetic and event detection, one bit wider than the counter so carries are visible.
  always_comb begin
    step_ext_s = {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
    sum_s      = {1'b0, data_r} + step_ext_s;
    diff_s     = {1'b0, data_r} - step_ext_s;
    ovf_s      = (sum_s > {1'b0, lim_i});
    unf_s      = (step_ext_s > {1'b0, data_r});
    // A zero step never counts, so it can never produce a terminal event.
    count_s    = e_i && (state_r == ST_RUN) && (step_i != {STEP_WIDTH{1'b0}});
    term_s     = count_s && (d_i ? unf_s : ovf_s);
    clamp_s    = (mode_i == MODE_SAT) || (mode_i == MODE_ONESHOT);
    load_val_s = (data_i > lim_i) ? lim_i : data_i;
  end

  // State register and registered outputs.
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_RUN;
      data_r  <= {DATA_WIDTH{1'b0}};
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      cout_r  <= cout_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic: STOP only on a one-shot terminal event, left only by load.
  always_comb begin
    state_nxt_s = state_r;
    if (load_i) begin
      state_nxt_s = ST_RUN;
    end else if (term_s && (mode_i == MODE_ONESHOT)) begin
      state_nxt_s = ST_STOP;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output logic: next counter value, terminal pulse and done flag.
  always_comb begin
    data_nxt_s = data_r;
    cout_nxt_s = 1'b0;
    done_nxt_s = done_r;
    if (load_i) begin
      data_nxt_s = load_val_s;
      cout_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
    end else if (term_s) begin
      cout_nxt_s = 1'b1;
      case ({d_i, clamp_s})
        2'b00:   data_nxt_s = {DATA_WIDTH{1'b0}};
        2'b01:   data_nxt_s = lim_i;
        2'b10:   data_nxt_s = lim_i;
        2'b11:   data_nxt_s = {DATA_WIDTH{1'b0}};
        default: data_nxt_s = {DATA_WIDTH{1'b0}};
      endcase
      if (mode_i == MODE_ONESHOT) begin
        done_nxt_s = 1'b1;
      end else begin
        done_nxt_s = done_r;
      end
    end else if (count_s) begin
      data_nxt_s = d_i ? diff_s[DATA_WIDTH-1:0] : sum_s[DATA_WIDTH-1:0];
    end else begin
      data_nxt_s = data_r;
    end
  end

  assign data_o = data_r;
  assign cout   = cout_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_counter_updown_modload.sv
// Directed self-checking bench for counter_updown_modload with hand-computed expectations.
module tb_counter_updown_modload;

  logic       Clk;
  logic       RST_N;
  logic       e_i;
  logic       d_i;
  logic       load_i;
  logic [7:0] data_i;
  logic [7:0] lim_i;
  logic [3:0] step_i;
  logic [1:0] mode_i;
  logic [7:0] data_o;
  logic       cout;
  logic       done_o;

  int errors_r = 0;
  int checks_r = 0;

  counter_updown_modload #(.DATA_WIDTH(8), .STEP_WIDTH(4)) dut (
    .Clk    (Clk),
    .RST_N  (RST_N),
    .e_i    (e_i),
    .d_i    (d_i),
    .load_i (load_i),
    .data_i (data_i),
    .lim_i  (lim_i),
    .step_i (step_i),
    .mode_i (mode_i),
    .data_o (data_o),
    .cout   (cout),
    .done_o (done_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val);
    load_i = 1'b1;
    data_i = val;
    tick();
    load_i = 1'b0;
  endtask

  task automatic chk3(input string tag, input logic [7:0] d, input logic c, input logic dn);
    check({tag, ".data"}, {24'd0, data_o}, {24'd0, d});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
    check({tag, ".done"}, {31'd0, done_o}, {31'd0, dn});
  endtask

  logic [7:0] seq_d[4];
  logic       seq_c[4];

  initial begin
    RST_N  = 1'b0;
    e_i    = 1'b0;
    d_i    = 1'b0;
    load_i = 1'b0;
    data_i = 8'd0;
    lim_i  = 8'd255;
    step_i = 4'd1;
    mode_i = 2'b00;
    #12;
    chk3("reset", 8'd0, 1'b0, 1'b0);
    tick();
    RST_N = 1'b1;

    // 1: full-range wrap up, then down underflow
    e_i = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("wrap_up.data", {24'd0, data_o}, i % 256);
      check("wrap_up.cout", {31'd0, cout}, (i == 256) ? 32'd1 : 32'd0);
    end
    d_i = 1'b1;
    tick();
    chk3("wrap_dn0", 8'd255, 1'b1, 1'b0);
    tick();
    chk3("wrap_dn1", 8'd254, 1'b0, 1'b0);

    // 2: lim=9 step=3 wrap
    e_i = 1'b0; d_i = 1'b0; lim_i = 8'd9; step_i = 4'd3;
    do_load(8'd0);
    chk3("l9_load", 8'd0, 1'b0, 1'b0);
    e_i = 1'b1;
    seq_d = '{8'd3, 8'd6, 8'd9, 8'd0};
    seq_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("l9_up", seq_d[i], seq_c[i], 1'b0);
    end
    e_i = 1'b0;
    do_load(8'd9);
    e_i = 1'b1; d_i = 1'b1;
    seq_d = '{8'd6, 8'd3, 8'd0, 8'd9};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("l9_dn", seq_d[i], seq_c[i], 1'b0);
    end

    // 3: saturate at 200
    e_i = 1'b0; d_i = 1'b0; mode_i = 2'b01; lim_i = 8'd200; step_i = 4'd1;
    do_load(8'd198);
    e_i = 1'b1;
    seq_d = '{8'd199, 8'd200, 8'd200, 8'd200};
    seq_c = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("sat", seq_d[i], seq_c[i], 1'b0);
    end

    // 4: one-shot lim=5 step=2
    e_i = 1'b0; mode_i = 2'b10; lim_i = 8'd5; step_i = 4'd2;
    do_load(8'd0);
    e_i = 1'b1;
    tick(); chk3("os0", 8'd2, 1'b0, 1'b0);
    tick(); chk3("os1", 8'd4, 1'b0, 1'b0);
    tick(); chk3("os2", 8'd5, 1'b1, 1'b1);
    tick(); chk3("os_hold0", 8'd5, 1'b0, 1'b1);
    mode_i = 2'b00;
    tick(); chk3("os_hold_wrapmode", 8'd5, 1'b0, 1'b1);
    e_i = 1'b0;
    do_load(8'd1);
    chk3("os_reload", 8'd1, 1'b0, 1'b0);
    e_i = 1'b1;
    tick(); chk3("os_resume", 8'd3, 1'b0, 1'b0);

    // 5: load and limit corners
    e_i = 1'b0; mode_i = 2'b00; lim_i = 8'd20; step_i = 4'd1;
    do_load(8'd50);
    chk3("load_clamp", 8'd20, 1'b0, 1'b0);
    lim_i = 8'd100; e_i = 1'b1;
    do_load(8'd7);
    chk3("load_wins", 8'd7, 1'b0, 1'b0);
    e_i = 1'b0;
    do_load(8'd40);
    lim_i = 8'd10; mode_i = 2'b01; e_i = 1'b1;
    tick(); chk3("limdrop_sat", 8'd10, 1'b1, 1'b0);
    e_i = 1'b0; lim_i = 8'd100;
    do_load(8'd40);
    lim_i = 8'd10; mode_i = 2'b00; e_i = 1'b1;
    tick(); chk3("limdrop_wrap", 8'd0, 1'b1, 1'b0);
    e_i = 1'b0; lim_i = 8'd100;
    do_load(8'd40);
    lim_i = 8'd10; d_i = 1'b1; e_i = 1'b1;
    tick(); chk3("limdrop_dn", 8'd39, 1'b0, 1'b0);
    step_i = 4'd0;
    tick(); chk3("step0", 8'd39, 1'b0, 1'b0);
    e_i = 1'b0; step_i = 4'd3;
    tick(); chk3("en0_hold", 8'd39, 1'b0, 1'b0);
    lim_i = 8'd0; d_i = 1'b0;
    do_load(8'd0);
    e_i = 1'b1;
    tick(); chk3("lim0_up", 8'd0, 1'b1, 1'b0);
    d_i = 1'b1;
    tick(); chk3("lim0_dn", 8'd0, 1'b1, 1'b0);

    // 6: async reset mid-count and mid-STOP
    e_i = 1'b0; d_i = 1'b0; lim_i = 8'd255; step_i = 4'd1; mode_i = 2'b00;
    do_load(8'd10);
    e_i = 1'b1;
    tick(); chk3("pre_rst", 8'd11, 1'b0, 1'b0);
    RST_N = 1'b0; #1;
    chk3("rst_midcount", 8'd0, 1'b0, 1'b0);
    #2 RST_N = 1'b1;
    tick(); chk3("rst_resume", 8'd1, 1'b0, 1'b0);
    e_i = 1'b0; mode_i = 2'b10; lim_i = 8'd3; step_i = 4'd2;
    do_load(8'd2);
    e_i = 1'b1;
    tick(); chk3("stop_entry", 8'd3, 1'b1, 1'b1);
    RST_N = 1'b0; #1;
    chk3("rst_midstop", 8'd0, 1'b0, 1'b0);
    #2 RST_N = 1'b1;
    mode_i = 2'b00; lim_i = 8'd255; step_i = 4'd1;
    tick(); chk3("stop_rst_resume", 8'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule
